// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: serialises fetch (I) and load/store (D)
// accesses, absorbs read latency and returns data with a done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [2:0] LAT = 3'(MEM_LAT);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_n;
  logic              own_d, own_d_n;
  logic              we_q, we_n;
  logic [2:0]        lat_cnt, lat_n;
  logic [SW-1:0]     starve_cnt, starve_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic              i_gnt_n, d_gnt_n;
  logic              i_done_n, d_done_n;
  logic              wr_n, busy_n;
  logic              grant_d, grant_i;

  // I wins only once D has taken STARVE_MAX grants in a row over it
  assign grant_d = d_req && !(i_req && starve_cnt == SMAX);
  assign grant_i = i_req && !grant_d;

  always_comb begin
    state_n  = state;
    own_d_n  = own_d;
    we_n     = we_q;
    lat_n    = lat_cnt;
    starve_n = starve_cnt;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    rdata_n  = rdata;
    i_gnt_n  = 1'b0;
    d_gnt_n  = 1'b0;
    i_done_n = 1'b0;
    d_done_n = 1'b0;
    wr_n     = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_n = ACCESS;
            own_d_n = 1'b1;
            we_n    = d_we;
            wr_n    = d_we;
            addr_n  = d_addr;
            wdata_n = d_wdata;
            lat_n   = 3'd1;
            d_gnt_n = 1'b1;
            if (!i_req)
              starve_n = '0;
            else if (starve_cnt != SMAX)
              starve_n = starve_cnt + 1'b1;
          end
          grant_i: begin
            state_n  = ACCESS;
            own_d_n  = 1'b0;
            we_n     = 1'b0;
            addr_n   = i_addr;
            lat_n    = 3'd1;
            i_gnt_n  = 1'b1;
            starve_n = '0;
          end
          default: starve_n = '0;
        endcase
      end
      ACCESS: begin
        if (we_q || lat_cnt == LAT) begin
          state_n  = DONE;
          i_done_n = !own_d;
          d_done_n = own_d;
          if (!we_q)
            rdata_n = mem_rdata;
        end else begin
          lat_n = lat_cnt + 3'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      rdata      <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      own_d      <= own_d_n;
      we_q       <= we_n;
      lat_cnt    <= lat_n;
      starve_cnt <= starve_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      mem_wr     <= wr_n;
      rdata      <= rdata_n;
      i_gnt      <= i_gnt_n;
      d_gnt      <= d_gnt_n;
      i_done     <= i_done_n;
      d_done     <= d_done_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected
// completions, timing and arbitration-order checks.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_done, d_gnt, d_done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, busy;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  bit   gnt_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cycles = 0;
  logic prev_gnt = 1'b0;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
    .Clk(clk), .Reset(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wr)
      mem[mem_addr[9:2]] <= mem_wdata;
    else if (pl_en)
      mem[pl_a] <= pl_d;
  end

  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse shape, exclusivity and scoreboard pop on done
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cycles++;
      check("wr_in_access", 32'(busy), 1);
    end
    if (i_gnt || d_gnt) begin
      gnt_log.push_back(d_gnt);
      check("gnt_excl", 32'(i_gnt & d_gnt), 0);
      check("gnt_pulse", 32'(prev_gnt), 0);
    end
    prev_gnt = i_gnt | d_gnt;
    if (i_done || d_done) begin
      check("done_excl", 32'(i_done & d_done), 0);
      check("done_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("done_owner", 32'(d_done), 32'(e.is_d));
        if (!e.we)
          check("rdata", rdata, e.data);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a = a[9:2];
    pl_d = d;
    ref_mem[a[9:2]] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic expect_xfer(input bit is_d, input bit we,
                             input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    if (we)
      ref_mem[a[9:2]] = wd;
    e.is_d = is_d;
    e.we = we;
    e.data = we ? 32'h0 : ref_mem[a[9:2]];
    sb.push_back(e);
  endtask

  task automatic do_req(input bit is_d, input bit we,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat);
    int tg, td, k;
    tg = -1;
    td = -1;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    k = 0;
    while (tg < 0 && k < 80) begin
      @(negedge clk);
      if (is_d ? d_gnt : i_gnt) tg = cyc;
      k++;
    end
    check("gnt_seen", 32'(tg >= 0), 1);
    check("gnt_addr", mem_addr, a);
    check("gnt_wr", 32'(mem_wr), 32'(we));
    if (is_d) begin
      d_addr = ~a; d_wdata = ~wd; d_we = ~we;
    end else begin
      i_addr = ~a;
    end
    k = 0;
    while (td < 0 && k < 80) begin
      @(negedge clk);
      if (is_d ? d_done : i_done) td = cyc;
      k++;
    end
    check("done_seen", 32'(td >= 0), 1);
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
    lat = td - tg;
  endtask

  initial begin
    int lat_a, lat_b, k, w0;
    bit seen;
    bit order5 [6];
    order5 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'h0;
    preload(32'h00, 32'h8C220004);
    preload(32'h10, 32'h11111111);
    preload(32'h20, 32'h22222222);
    preload(32'h24, 32'h33333333);

    // 1: reset holds everything low despite both requests
    @(negedge clk);
    check("rst_gnt", {30'h0, i_gnt, d_gnt}, 0);
    check("rst_done", {30'h0, i_done, d_done}, 0);
    check("rst_busy_wr", {30'h0, busy, mem_wr}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    expect_xfer(1'b1, 1'b0, 32'h10, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_dgnt", {30'h0, i_gnt, d_gnt}, 32'h1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      seen = d_done;
      k++;
    end
    check("post_rst_done", 32'(seen), 1);
    d_req = 1'b0;
    i_req = 1'b0;

    // 2: fetch with MEM_LAT read latency
    expect_xfer(1'b0, 1'b0, 32'h0, 32'h0);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, lat_a);
    check("fetch_lat", lat_a, LAT);

    // 3: store pulses mem_wr once, then read back
    w0 = wr_cycles;
    expect_xfer(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    do_req(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, lat_a);
    check("store_lat", lat_a, 1);
    check("store_wr_cycles", wr_cycles - w0, 1);
    expect_xfer(1'b1, 1'b0, 32'h40, 32'h0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, lat_a);
    check("load_lat", lat_a, LAT);

    // 4: simultaneous requests, D first
    gnt_log.delete();
    expect_xfer(1'b1, 1'b0, 32'h20, 32'h0);
    expect_xfer(1'b0, 1'b0, 32'h24, 32'h0);
    fork
      do_req(1'b1, 1'b0, 32'h20, 32'h0, lat_a);
      do_req(1'b0, 1'b0, 32'h24, 32'h0, lat_b);
    join
    check("t4_ngnt", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t4_first", 32'(gnt_log[0]), 1);
      check("t4_second", 32'(gnt_log[1]), 0);
    end

    // 5: starvation limit forces I after four D grants
    gnt_log.delete();
    expect_xfer(1'b1, 1'b1, 32'h30, 32'hAAAA0001);
    expect_xfer(1'b1, 1'b0, 32'h30, 32'h0);
    expect_xfer(1'b1, 1'b1, 32'h34, 32'h00000055);
    expect_xfer(1'b1, 1'b0, 32'h20, 32'h0);
    expect_xfer(1'b0, 1'b0, 32'h00, 32'h0);
    expect_xfer(1'b1, 1'b0, 32'h10, 32'h0);
    fork
      begin
        do_req(1'b1, 1'b1, 32'h30, 32'hAAAA0001, lat_a);
        do_req(1'b1, 1'b0, 32'h30, 32'h0, lat_a);
        do_req(1'b1, 1'b1, 32'h34, 32'h00000055, lat_a);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, lat_a);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, lat_a);
      end
      do_req(1'b0, 1'b0, 32'h00, 32'h0, lat_b);
    join
    check("t5_ngnt", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gnt_log.size())
        check($sformatf("t5_order%0d", i), 32'(gnt_log[i]), 32'(order5[i]));

    // 6: reset mid-load aborts with no done
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      seen = d_gnt;
      k++;
    end
    check("t6_gnt", 32'(seen), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    check("t6_wr_done", {30'h0, mem_wr, d_done}, 0);
    d_req = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    expect_xfer(1'b1, 1'b1, 32'h44, 32'h12345678);
    do_req(1'b1, 1'b1, 32'h44, 32'h12345678, lat_a);
    check("t6_store_lat", lat_a, 1);
    expect_xfer(1'b1, 1'b0, 32'h44, 32'h0);
    do_req(1'b1, 1'b0, 32'h44, 32'h0, lat_a);
    check("t6_load_lat", lat_a, LAT);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
